// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue stage: opcodes, FSM states
// and the latched instruction record.
package alu_pkg;

    localparam int WIDTH = 16;
    localparam int NREG  = 8;
    localparam int AW    = $clog2(NREG);

    typedef enum logic [2:0] {
        OP_NEG    = 3'd0,
        OP_INC    = 3'd1,
        OP_ADD    = 3'd2,
        OP_ADDSHR = 3'd3,
        OP_AND    = 3'd4,
        OP_OR     = 3'd5,
        OP_PACK   = 3'd6,
        OP_ILL    = 3'd7
    } opcode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OPER = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_e;

    typedef struct packed {
        opcode_e         op;
        logic [AW-1:0]   rd;
        logic [AW-1:0]   ra;
        logic [AW-1:0]   rb;
        logic            c;
    } instr_t;

endpackage

// File: rtl/alu_regfile.sv
// NREG x WIDTH register file: two operand read ports, one debug read port,
// one synchronous write port. Entry 0 is hardwired to zero.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int WIDTH = alu_pkg::WIDTH,
    parameter int NREG  = alu_pkg::NREG,
    parameter int AW    = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr_a,
    output logic [WIDTH-1:0] o_rdata_a,
    input  logic [AW-1:0]    i_raddr_b,
    output logic [WIDTH-1:0] o_rdata_b,
    input  logic [AW-1:0]    i_raddr_d,
    output logic [WIDTH-1:0] o_rdata_d
);

    logic [WIDTH-1:0] r_mem [NREG];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mem <= '{default: '0};
        end else if (i_we && (i_waddr != '0)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Entry 0 is never written, but force the read as well so it stays zero
    // regardless of how the storage is mapped.
    assign o_rdata_a = (i_raddr_a == '0) ? '0 : r_mem[i_raddr_a];
    assign o_rdata_b = (i_raddr_b == '0) ? '0 : r_mem[i_raddr_b];
    assign o_rdata_d = (i_raddr_d == '0) ? '0 : r_mem[i_raddr_d];

endmodule

// File: rtl/alu_issue_unit.sv
// Serialized four-cycle issue stage: fetch operands, drive the external ALU,
// capture result and flags, write back. One instruction in flight at a time.
module alu_issue_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = alu_pkg::WIDTH,
    parameter int NREG  = alu_pkg::NREG
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2:0]              in_op,
    input  logic [$clog2(NREG)-1:0] in_rd,
    input  logic [$clog2(NREG)-1:0] in_ra,
    input  logic [$clog2(NREG)-1:0] in_rb,
    input  logic                    in_c,
    input  logic                    ld_valid,
    input  logic [$clog2(NREG)-1:0] ld_addr,
    input  logic [WIDTH-1:0]        ld_data,
    input  logic [$clog2(NREG)-1:0] rd_addr,
    output logic [WIDTH-1:0]        rd_data,
    output logic [WIDTH-1:0]        alu_a,
    output logic [WIDTH-1:0]        alu_b,
    output logic                    alu_c,
    output logic [2:0]              alu_op,
    input  logic [WIDTH-1:0]        alu_w,
    input  logic                    alu_zero,
    input  logic                    alu_neg,
    output logic                    done,
    output logic                    flag_z,
    output logic                    flag_n,
    output logic                    err
);

    localparam int AW = $clog2(NREG);

    state_e           r_state;
    state_e           w_next;
    instr_t           r_instr;
    logic [WIDTH-1:0] r_res;
    logic             r_rz;
    logic             r_rn;

    logic             w_we;
    logic [AW-1:0]    w_waddr;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_opa;
    logic [WIDTH-1:0] w_opb;

    alu_regfile #(
        .WIDTH (WIDTH),
        .NREG  (NREG),
        .AW    (AW)
    ) u_rf (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_we      (w_we),
        .i_waddr   (w_waddr),
        .i_wdata   (w_wdata),
        .i_raddr_a (r_instr.ra),
        .o_rdata_a (w_opa),
        .i_raddr_b (r_instr.rb),
        .o_rdata_b (w_opb),
        .i_raddr_d (rd_addr),
        .o_rdata_d (rd_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Direct loads and write-back share the single write port; they can
    // never collide because loads are only honoured in IDLE.
    always_comb begin
        w_next   = r_state;
        in_ready = 1'b0;
        done     = 1'b0;
        w_we     = 1'b0;
        w_waddr  = ld_addr;
        w_wdata  = ld_data;
        unique case (r_state)
            IDLE: begin
                in_ready = !ld_valid;
                w_we     = ld_valid;
                if (in_valid && !ld_valid) begin
                    w_next = OPER;
                end
            end
            OPER: w_next = EXEC;
            EXEC: w_next = WB;
            WB: begin
                done    = 1'b1;
                w_we    = (r_instr.op != OP_ILL);
                w_waddr = r_instr.rd;
                w_wdata = r_res;
                w_next  = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_instr <= '0;
            r_res   <= '0;
            r_rz    <= 1'b0;
            r_rn    <= 1'b0;
            alu_a   <= '0;
            alu_b   <= '0;
            alu_c   <= 1'b0;
            alu_op  <= '0;
            flag_z  <= 1'b0;
            flag_n  <= 1'b0;
            err     <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        r_instr <= '{op: opcode_e'(in_op), rd: in_rd, ra: in_ra,
                                     rb: in_rb, c: in_c};
                    end
                end
                OPER: begin
                    alu_a  <= w_opa;
                    alu_b  <= w_opb;
                    alu_c  <= r_instr.c;
                    alu_op <= r_instr.op;
                end
                EXEC: begin
                    r_res <= alu_w;
                    r_rz  <= alu_zero;
                    r_rn  <= alu_neg;
                end
                WB: begin
                    if (r_instr.op == OP_ILL) begin
                        err <= 1'b1;
                    end else begin
                        flag_z <= r_rz;
                        flag_n <= r_rn;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit with a behavioural ALU stage attached and an
// integer-arithmetic reference model of the register file and flags.
module tb_alu_issue_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [2:0]  in_rd, in_ra, in_rb;
    logic        in_c;
    logic        ld_valid;
    logic [2:0]  ld_addr;
    logic [15:0] ld_data;
    logic [2:0]  rd_addr;
    logic [15:0] rd_data;
    logic [15:0] alu_a, alu_b;
    logic        alu_c;
    logic [2:0]  alu_op;
    logic [15:0] alu_w;
    logic        alu_zero, alu_neg;
    logic        done, flag_z, flag_n, err;

    int n_checks = 0;
    int n_fail   = 0;

    int unsigned m_rf [8];
    bit          m_z, m_n, m_err;

    always #10 clk = ~clk;

    alu_issue_unit #(.WIDTH(16), .NREG(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_ra(in_ra), .in_rb(in_rb), .in_c(in_c),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_op(alu_op),
        .alu_w(alu_w), .alu_zero(alu_zero), .alu_neg(alu_neg),
        .done(done), .flag_z(flag_z), .flag_n(flag_n), .err(err)
    );

    // The team's combinational ALU stage.
    logic [15:0] shr_b;
    always_comb begin
        shr_b = $signed(alu_b) >>> 1;
        case (alu_op)
            3'd0:    alu_w = -alu_a;
            3'd1:    alu_w = alu_a + 16'd1;
            3'd2:    alu_w = alu_a + alu_b + {15'd0, alu_c};
            3'd3:    alu_w = alu_a + shr_b;
            3'd4:    alu_w = alu_a & alu_b;
            3'd5:    alu_w = alu_a | alu_b;
            3'd6:    alu_w = {alu_a[7:0], alu_b[7:0]};
            default: alu_w = 16'd0;
        endcase
    end
    assign alu_zero = (alu_w == 16'd0);
    assign alu_neg  = alu_w[15];

    function automatic int unsigned ref_alu(input int op, input int unsigned a,
                                            input int unsigned b, input int unsigned c);
        int sb, shr;
        case (op)
            0: return (65536 - a) % 65536;
            1: return (a + 1) % 65536;
            2: return (a + b + c) % 65536;
            3: begin
                sb  = (b >= 32768) ? int'(b) - 65536 : int'(b);
                shr = (sb - (sb & 1)) / 2;
                return int'(unsigned'(int'(a) + shr + 65536)) % 65536;
            end
            4: return a & b;
            5: return a | b;
            6: return (a % 256) * 256 + (b % 256);
            default: return 0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        foreach (m_rf[i]) m_rf[i] = 0;
        m_z = 0; m_n = 0; m_err = 0;
    endtask

    task automatic read_reg(input int a, output logic [15:0] d);
        rd_addr = 3'(a);
        #1;
        d = rd_data;
    endtask

    task automatic do_load(input int a, input int unsigned d);
        ld_valid = 1'b1;
        ld_addr  = 3'(a);
        ld_data  = 16'(d);
        tick();
        ld_valid = 1'b0;
        if (a != 0) m_rf[a] = d % 65536;
    endtask

    task automatic model_retire(input int op, input int rd, input int unsigned res);
        if (op == 7) begin
            m_err = 1;
        end else begin
            if (rd != 0) m_rf[rd] = res;
            m_z = (res == 0);
            m_n = (res >= 32768);
        end
    endtask

    // lat: cycles from accept edge to the cycle where done is seen (accept = 0);
    // -1 if the unit never became ready or never retired.
    task automatic issue(input int op, input int rd, input int ra, input int rb,
                         input int c, output int lat);
        int w = 0;
        int unsigned res;
        res = ref_alu(op, m_rf[ra], m_rf[rb], c);
        while (in_ready !== 1'b1 && w < 20) begin tick(); w++; end
        if (in_ready !== 1'b1) begin lat = -1; return; end
        in_valid = 1'b1; in_op = 3'(op); in_rd = 3'(rd); in_ra = 3'(ra);
        in_rb = 3'(rb); in_c = 1'(c);
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 10) begin tick(); lat++; end
        if (done !== 1'b1) begin lat = -1; return; end
        tick();
        model_retire(op, rd, res);
    endtask

    task automatic test_reset();
        logic [15:0] d;
        rst_n = 1'b0; in_valid = 1'b0; ld_valid = 1'b0; in_op = '0; in_rd = '0;
        in_ra = '0; in_rb = '0; in_c = 1'b0; ld_addr = '0; ld_data = '0; rd_addr = '0;
        tick(); tick();
        rst_n = 1'b1;
        model_reset();
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
        n_checks++; if ({flag_z, flag_n, err} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got=%b exp=000", {flag_z, flag_n, err}); end
        n_checks++; if ({alu_a, alu_b, alu_c, alu_op} !== 36'd0) begin n_fail++; $display("FAIL reset_alu got=%h exp=0", {alu_a, alu_b, alu_c, alu_op}); end
        for (int i = 0; i < 8; i++) begin
            read_reg(i, d);
            n_checks++; if (d !== 16'h0000) begin n_fail++; $display("FAIL reset_rf[%0d] got=%h exp=0000", i, d); end
        end
    endtask

    task automatic test_add_carry();
        int lat;
        logic [15:0] d;
        do_load(1, 16'h0005);
        do_load(2, 16'h0003);
        issue(2, 3, 1, 2, 1, lat);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL add_latency got=%0d exp=3", lat); end
        read_reg(3, d);
        n_checks++; if (d !== 16'h0009) begin n_fail++; $display("FAIL add_r3 got=%h exp=0009", d); end
        n_checks++; if ({flag_z, flag_n} !== 2'b00) begin n_fail++; $display("FAIL add_flags got=%b exp=00", {flag_z, flag_n}); end
    endtask

    task automatic test_negate();
        int lat;
        logic [15:0] d;
        issue(0, 4, 1, 0, 0, lat);
        read_reg(4, d);
        n_checks++; if (d !== 16'hFFFB) begin n_fail++; $display("FAIL neg_r4 got=%h exp=fffb", d); end
        n_checks++; if ({flag_z, flag_n} !== 2'b01) begin n_fail++; $display("FAIL neg_flags got=%b exp=01", {flag_z, flag_n}); end
    endtask

    task automatic test_shift_pack_r0();
        int lat;
        logic [15:0] d;
        do_load(5, 16'h8000);
        issue(3, 6, 2, 5, 0, lat);
        read_reg(6, d);
        n_checks++; if (d !== 16'hC003) begin n_fail++; $display("FAIL shradd_r6 got=%h exp=c003", d); end
        issue(6, 7, 1, 2, 0, lat);
        read_reg(7, d);
        n_checks++; if (d !== 16'h0503) begin n_fail++; $display("FAIL pack_r7 got=%h exp=0503", d); end
        issue(0, 0, 1, 0, 0, lat);
        read_reg(0, d);
        n_checks++; if (d !== 16'h0000) begin n_fail++; $display("FAIL r0_neg_r0 got=%h exp=0000", d); end
        n_checks++; if ({flag_z, flag_n} !== 2'b01) begin n_fail++; $display("FAIL r0_neg_flags got=%b exp=01", {flag_z, flag_n}); end
        issue(4, 0, 1, 2, 0, lat);
        read_reg(0, d);
        n_checks++; if (d !== 16'h0000) begin n_fail++; $display("FAIL r0_and_r0 got=%h exp=0000", d); end
        n_checks++; if ({flag_z, flag_n} !== 2'b00) begin n_fail++; $display("FAIL r0_and_flags got=%b exp=00", {flag_z, flag_n}); end
    endtask

    task automatic test_illegal();
        int lat;
        logic [15:0] d;
        issue(0, 0, 1, 0, 0, lat);
        issue(7, 3, 1, 2, 0, lat);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL ill_done got=%0d exp=3", lat); end
        read_reg(3, d);
        n_checks++; if (d !== 16'h0009) begin n_fail++; $display("FAIL ill_r3 got=%h exp=0009", d); end
        n_checks++; if ({flag_z, flag_n} !== 2'b01) begin n_fail++; $display("FAIL ill_flags got=%b exp=01", {flag_z, flag_n}); end
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL ill_err got=%b exp=1", err); end
        issue(1, 4, 1, 0, 0, lat);
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL ill_err_sticky got=%b exp=1", err); end
        read_reg(4, d);
        n_checks++; if (d !== 16'(m_rf[4])) begin n_fail++; $display("FAIL ill_after_r4 got=%h exp=%h", d, 16'(m_rf[4])); end
    endtask

    task automatic test_back_to_back();
        int unsigned res;
        logic [15:0] d;
        tick();
        in_valid = 1'b1; in_op = 3'd5; in_rd = 3'd6; in_ra = 3'd2; in_rb = 3'd1; in_c = 1'b0;
        ld_valid = 1'b1; ld_addr = 3'd2; ld_data = 16'h00F0;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL coll_ready_load got=%b exp=0", in_ready); end
        tick();
        m_rf[2] = 16'h00F0;
        ld_valid = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL coll_ready_after got=%b exp=1", in_ready); end
        tick();
        ld_valid = 1'b1; ld_addr = 3'd1; ld_data = 16'hDEAD;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_oper got=%b exp=0", in_ready); end
        tick();
        ld_valid = 1'b0;
        n_checks++; if ({alu_a, alu_b, alu_op} !== {16'h00F0, 16'(m_rf[1]), 3'd5}) begin n_fail++; $display("FAIL b2b_alu_in got=%h/%h/%0d exp=00f0/%h/5", alu_a, alu_b, alu_op, 16'(m_rf[1])); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_exec got=%b exp=0", in_ready); end
        tick();
        n_checks++; if ({done, in_ready} !== 2'b10) begin n_fail++; $display("FAIL b2b_wb got done,ready=%b exp=10", {done, in_ready}); end
        res = ref_alu(5, m_rf[2], m_rf[1], 0);
        tick();
        n_checks++; if ({done, in_ready} !== 2'b01) begin n_fail++; $display("FAIL b2b_cycle4 got done,ready=%b exp=01", {done, in_ready}); end
        in_valid = 1'b0;
        model_retire(5, 6, res);
        read_reg(6, d);
        n_checks++; if (d !== 16'(m_rf[6])) begin n_fail++; $display("FAIL b2b_r6 got=%h exp=%h", d, 16'(m_rf[6])); end
        read_reg(1, d);
        n_checks++; if (d !== 16'(m_rf[1])) begin n_fail++; $display("FAIL b2b_ld_ignored got=%h exp=%h", d, 16'(m_rf[1])); end
    endtask

    task automatic test_random();
        int lat, op, rd, ra, rb, c;
        logic [15:0] d;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 1) == 1)
                do_load(int'($urandom_range(0, 7)), $urandom_range(0, 65535));
            op = int'($urandom_range(0, 7));
            rd = int'($urandom_range(0, 7));
            ra = int'($urandom_range(0, 7));
            rb = int'($urandom_range(0, 7));
            c  = int'($urandom_range(0, 1));
            issue(op, rd, ra, rb, c, lat);
            n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL rnd_latency[%0d] got=%0d exp=3", n, lat); end
            read_reg(rd, d);
            n_checks++; if (d !== 16'(m_rf[rd])) begin n_fail++; $display("FAIL rnd_r%0d[%0d] op=%0d got=%h exp=%h", rd, n, op, d, 16'(m_rf[rd])); end
            n_checks++; if ({flag_z, flag_n, err} !== {m_z, m_n, m_err}) begin n_fail++; $display("FAIL rnd_flags[%0d] got=%b exp=%b", n, {flag_z, flag_n, err}, {m_z, m_n, m_err}); end
        end
    endtask

    task automatic test_reset_midop();
        logic [15:0] d;
        bit saw_done = 0;
        do_load(3, 16'h1234);
        in_valid = 1'b1; in_op = 3'd2; in_rd = 3'd5; in_ra = 3'd3; in_rb = 3'd3; in_c = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        model_reset();
        n_checks++; if ({done, in_ready} !== 2'b01) begin n_fail++; $display("FAIL rstmid_state got done,ready=%b exp=01", {done, in_ready}); end
        n_checks++; if ({flag_z, flag_n, err} !== 3'b000) begin n_fail++; $display("FAIL rstmid_flags got=%b exp=000", {flag_z, flag_n, err}); end
        n_checks++; if ({alu_a, alu_b, alu_c, alu_op} !== 36'd0) begin n_fail++; $display("FAIL rstmid_alu got=%h exp=0", {alu_a, alu_b, alu_c, alu_op}); end
        for (int i = 0; i < 8; i++) begin
            read_reg(i, d);
            n_checks++; if (d !== 16'h0000) begin n_fail++; $display("FAIL rstmid_rf[%0d] got=%h exp=0000", i, d); end
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done === 1'b1) saw_done = 1;
        end
        n_checks++; if (saw_done) begin n_fail++; $display("FAIL rstmid_dropped got done=1 exp=0"); end
    endtask

    initial begin
        test_reset();
        test_add_carry();
        test_negate();
        test_shift_pack_r0();
        test_illegal();
        test_back_to_back();
        test_random();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout after %0d checks", n_checks);
        $fatal(1, "timeout");
    end

endmodule
